// File: rtl/flow_led_pkg.sv
// Shared types and constants for the flowing LED controller.
package flow_led_pkg;

    localparam int CNT_W = 23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_SHL   = 2'd0,
        MODE_SHR   = 2'd1,
        MODE_PING  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

endpackage

// File: rtl/led_step_timer.sv
// Step counter: counts 0..T_STEP while enabled, holds at 0 otherwise,
// and flags the last cycle of each step.
module led_step_timer
    import flow_led_pkg::*;
#(
    parameter logic [CNT_W-1:0] T_STEP = 23'd5_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             step_done
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST || !en || r_count == T_STEP) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count     = r_count;
    assign step_done = en && (r_count == T_STEP);

endmodule

// File: rtl/flowing_led_ctrl.sv
// Flowing LED controller: IDLE/RUN/DRAIN sequencer driving N_LED outputs in
// one of four patterns. Define FLOW_LED_PWM_EN to gate lit LEDs to count <= T_ON.
module flowing_led_ctrl
    import flow_led_pkg::*;
#(
    parameter int               N_LED  = 4,
    parameter logic [CNT_W-1:0] T_STEP = 23'd5_000_000,
    parameter logic [CNT_W-1:0] T_ON   = 23'd1_250_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic [1:0]       MODE,
    output logic             BUSY,
    output logic             STEP_DONE,
    output logic [N_LED-1:0] LED_out
);

    localparam int               POS_W    = $clog2(N_LED);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
    localparam logic [N_LED-1:0] LED_LSB  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] LED_MSB  = {1'b1, {(N_LED-1){1'b0}}};

    if (N_LED < 2 || N_LED > 16 || T_ON >= T_STEP) begin : g_bad_params
        $error("flowing_led_ctrl: N_LED must be 2..16 and T_ON < T_STEP");
    end

    state_t           r_state, w_state_nxt;
    mode_t            r_mode, w_mode_nxt;
    logic [POS_W-1:0] r_pos, w_pos_nxt;
    logic             r_dir, w_dir_nxt;       // 1 = counting up
    logic [N_LED-1:0] r_led, w_led_nxt;
    logic [CNT_W-1:0] w_count, w_cnt_nxt;
    logic             w_step_done, w_busy, w_lit;

    assign w_busy = (r_state != ST_IDLE);

    led_step_timer #(.T_STEP(T_STEP)) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .en        (w_busy),
        .count     (w_count),
        .step_done (w_step_done)
    );

    // Position 0 maps to LED 0 for shift-left and ping-pong, LED N-1 for
    // shift-right; blink uses only the parity of the position.
    function automatic logic [N_LED-1:0] led_pattern(input mode_t m, input logic [POS_W-1:0] p);
        case (m)
            MODE_SHR:   return LED_MSB >> p;
            MODE_BLINK: return (p[0] == 1'b0) ? '1 : '0;
            default:    return LED_LSB << p;
        endcase
    endfunction

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;

        case (r_state)
            ST_IDLE: begin
                if (START && !STOP) begin
                    w_state_nxt = ST_RUN;
                    w_mode_nxt  = mode_t'(MODE);
                end
            end
            ST_RUN: begin
                // A stop on the last cycle of a step ends the sequence right there.
                if (STOP) w_state_nxt = w_step_done ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_step_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (r_state == ST_IDLE || w_state_nxt == ST_IDLE) begin
            w_pos_nxt = '0;
            w_dir_nxt = 1'b1;
        end else if (w_step_done) begin
            case (r_mode)
                MODE_PING: begin
                    if (r_dir) begin
                        if (r_pos == POS_LAST) begin
                            w_dir_nxt = 1'b0;
                            w_pos_nxt = r_pos - POS_W'(1);
                        end else begin
                            w_pos_nxt = r_pos + POS_W'(1);
                        end
                    end else begin
                        if (r_pos == '0) begin
                            w_dir_nxt = 1'b1;
                            w_pos_nxt = POS_W'(1);
                        end else begin
                            w_pos_nxt = r_pos - POS_W'(1);
                        end
                    end
                end
                MODE_BLINK: w_pos_nxt = (r_pos == '0) ? POS_W'(1) : '0;
                default:    w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + POS_W'(1);
            endcase
        end

        // The LED register is loaded from next-cycle count/position so it
        // lines up with the step the counter is in.
        w_cnt_nxt = (!w_busy || w_step_done) ? '0 : w_count + CNT_W'(1);
`ifdef FLOW_LED_PWM_EN
        w_lit = (w_cnt_nxt <= T_ON);
`else
        w_lit = (w_cnt_nxt <= T_STEP);
`endif

        if (w_state_nxt == ST_IDLE || !w_lit) begin
            w_led_nxt = '0;
        end else begin
            w_led_nxt = led_pattern(w_mode_nxt, w_pos_nxt);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_SHL;
            r_pos   <= '0;
            r_dir   <= 1'b1;
            r_led   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_pos   <= w_pos_nxt;
            r_dir   <= w_dir_nxt;
            r_led   <= w_led_nxt;
        end
    end

    assign BUSY      = w_busy;
    assign STEP_DONE = w_step_done;
    assign LED_out   = r_led;

endmodule

// File: tb/tb_flowing_led_ctrl.sv
// Self-checking bench for flowing_led_ctrl (N_LED=4, T_STEP=9, T_ON=2):
// directed pattern tables and corner sequences plus a randomized run.
module tb_flowing_led_ctrl;

    localparam int N     = 4;
    localparam int T_ST  = 9;
    localparam int T_ONV = 2;
    localparam int P     = T_ST + 1;

    logic       CLK, RST, START, STOP;
    logic [1:0] MODE;
    logic       BUSY, STEP_DONE;
    logic [3:0] LED_out;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Reference model: a sequence is described by the edge it was accepted
    // on, its mode and the step index on which it must end.
    bit         m_active = 1'b0;
    int         m_e0     = 0;
    int         m_end    = -1;
    logic [1:0] m_mode   = 2'd0;

    typedef struct {
        logic [1:0]      mode;
        int              n_steps;
        logic [7:0][3:0] exp;
    } seq_t;

    seq_t seqs[4];

    flowing_led_ctrl #(.N_LED(N), .T_STEP(23'd9), .T_ON(23'd2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .STOP      (STOP),
        .MODE      (MODE),
        .BUSY      (BUSY),
        .STEP_DONE (STEP_DONE),
        .LED_out   (LED_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit lit(input int c);
`ifdef FLOW_LED_PWM_EN
        return c <= T_ONV;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [3:0] ref_pattern(input logic [1:0] m, input int step);
        int idx;
        int p;
        case (m)
            2'd0: idx = step % N;
            2'd1: idx = N - 1 - (step % N);
            2'd2: begin
                p   = step % (2*N - 2);
                idx = (p < N) ? p : (2*N - 2 - p);
            end
            default: return (step % 2 == 0) ? 4'hF : 4'h0;
        endcase
        return 4'(1 << idx);
    endfunction

    task automatic model_edge();
        int k;
        int step;
        if (RST) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (START && !STOP) begin
                m_active = 1'b1;
                m_e0     = edge_n;
                m_mode   = MODE;
                m_end    = -1;
            end
        end else begin
            k    = edge_n - 1 - m_e0;
            step = k / P;
            if (STOP && m_end < 0) m_end = step;
            if ((k % P) == T_ST && step == m_end) m_active = 1'b0;
        end
    endtask

    task automatic tick();
        int k;
        int c;
        logic [3:0] e_led;
        logic       e_busy, e_done;
        @(posedge CLK);
        edge_n++;
        model_edge();
        #1;
        if (!m_active) begin
            e_led = 4'h0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            k      = edge_n - m_e0;
            c      = k % P;
            e_busy = 1'b1;
            e_done = (c == T_ST);
            e_led  = lit(c) ? ref_pattern(m_mode, k / P) : 4'h0;
        end
        check("model_led", LED_out, e_led);
        check("model_busy", BUSY, e_busy);
        check("model_done", STEP_DONE, e_done);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3*P && BUSY; i++) tick();
        check({name, "_idle_busy"}, BUSY, 0);
        check({name, "_idle_led"}, LED_out, 0);
    endtask

    task automatic run_seq(input seq_t sq);
        MODE  = sq.mode;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int s = 0; s < sq.n_steps; s++) begin
            for (int c = 0; c < P; c++) begin
                if (s == 2 && c == 0) MODE = ~sq.mode;
                check($sformatf("seq m%0d s%0d c%0d led", sq.mode, s, c), LED_out,
                      lit(c) ? sq.exp[s] : 4'h0);
                check($sformatf("seq m%0d s%0d c%0d done", sq.mode, s, c), STEP_DONE, c == T_ST);
                check($sformatf("seq m%0d s%0d c%0d busy", sq.mode, s, c), BUSY, 1);
                tick();
            end
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        wait_idle($sformatf("seq m%0d", sq.mode));
    endtask

    initial begin
        seqs[0] = '{mode: 2'd0, n_steps: 5, exp: {4'h0, 4'h0, 4'h0, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1}};
        seqs[1] = '{mode: 2'd1, n_steps: 5, exp: {4'h0, 4'h0, 4'h0, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8}};
        seqs[2] = '{mode: 2'd2, n_steps: 8, exp: {4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1}};
        seqs[3] = '{mode: 2'd3, n_steps: 5, exp: {4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF}};

        RST = 1'b1; START = 1'b0; STOP = 1'b0; MODE = 2'd0;
        repeat (3) tick();
        RST = 1'b0;
        check("reset_led", LED_out, 0);
        check("reset_busy", BUSY, 0);
        check("reset_done", STEP_DONE, 0);

        // Pattern tables, each with a MODE change mid-run that must be ignored.
        foreach (seqs[i]) run_seq(seqs[i]);

        // STOP at cycle 4 of a step; START during DRAIN is ignored.
        MODE = 2'd0; START = 1'b1; tick(); START = 1'b0;
        repeat (4) tick();
        STOP = 1'b1; tick(); STOP = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
        repeat (3) tick();
        check("stop_last_done", STEP_DONE, 1);
        check("stop_last_busy", BUSY, 1);
        check("stop_last_led", LED_out, lit(T_ST) ? 4'h1 : 4'h0);
        tick();
        check("stop_after_led", LED_out, 0);
        check("stop_after_busy", BUSY, 0);
        check("stop_after_done", STEP_DONE, 0);
        repeat (3) tick();
        check("drain_start_ignored", BUSY, 0);

        // START and STOP together in IDLE.
        START = 1'b1; STOP = 1'b1; tick(); START = 1'b0; STOP = 1'b0;
        check("startstop_busy", BUSY, 0);
        check("startstop_led", LED_out, 0);
        tick();
        check("startstop_busy2", BUSY, 0);

        // Reset held 3 cycles mid-run, START during reset loses to RST.
        MODE = 2'd1; START = 1'b1; tick(); START = 1'b0;
        repeat (25) tick();
        RST = 1'b1; tick();
        check("midrst_led", LED_out, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_done", STEP_DONE, 0);
        START = 1'b1; tick(); START = 1'b0; tick();
        RST = 1'b0;
        check("midrst_hold_busy", BUSY, 0);
        MODE = 2'd0; START = 1'b1; tick(); START = 1'b0;
        check("restart_led", LED_out, lit(0) ? 4'h1 : 4'h0);
        check("restart_busy", BUSY, 1);
        repeat (P) tick();
        check("restart_step1_led", LED_out, lit(0) ? 4'h2 : 4'h0);
        STOP = 1'b1; tick(); STOP = 1'b0;
        wait_idle("restart");

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            RST   = ($urandom_range(0, 299) == 0);
            START = ($urandom_range(0, 15) == 0);
            STOP  = ($urandom_range(0, 59) == 0);
            MODE  = 2'($urandom);
            tick();
        end
        RST = 1'b0; START = 1'b0; STOP = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
